mem_copy_engine: RTL and testbench

- Initiator for the 8-bit-address / 16-bit-data synchronous memory port (address, data_in, write_enable, read_enable, data_out).
- On a start command, reads a contiguous block of words from a source region and writes them to a destination region, one word at a time.
- Reports busy/done status and a 16-bit additive checksum of the copied words.
- Sits between the CPU control logic and the memory module as its only master while busy.

---
 rtl/mem_copy_engine.sv | 131 +++++++++++++
 tb/tb_mem_copy_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the 8-bit-address / 16-bit-data synchronous memory port.
// Copies words strictly ascending, 3 cycles per word (read, capture, write), with an additive checksum.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int unsigned MAX_LEN = 1 << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [LEN_W-1:0]    idx_d;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [DATA_W-1:0]   checksum_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   word_q;
  logic                we_q;
  logic                re_q;

  assign idx_d = idx_q + LEN_W'(1);

  // Controller: all memory-side outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            checksum_q <= '0;
            error_q    <= 1'b0;
            if (length == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else if (length > LEN_W'(MAX_LEN)) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              src_q   <= src_addr;
              dst_q   <= dst_addr;
              len_q   <= length;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              re_q    <= 1'b1;
              addr_q  <= src_addr;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          re_q    <= 1'b0;
          state_q <= S_CAP;
        end
        S_CAP: begin
          word_q     <= mem_data_out;
          checksum_q <= checksum_q + mem_data_out;
          we_q       <= 1'b1;
          addr_q     <= dst_q + idx_q[ADDR_W-1:0];
          state_q    <= S_WR;
        end
        S_WR: begin
          we_q <= 1'b0;
          if (idx_d < len_q) begin
            idx_q   <= idx_d;
            re_q    <= 1'b1;
            addr_q  <= src_q + idx_d[ADDR_W-1:0];
            state_q <= S_RD;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign checksum         = checksum_q;
  assign mem_address      = addr_q;
  assign mem_data_in      = word_q;
  assign mem_write_enable = we_q;
  assign mem_read_enable  = re_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural memory plus an array-based copy model.
module tb_mem_copy_engine;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [8:0]  length = '0;
  logic        busy, done, error;
  logic [15:0] checksum;
  logic [7:0]  mem_address;
  logic [15:0] mem_data_in;
  logic        mem_write_enable, mem_read_enable;
  logic [15:0] mem_data_out = '0;

  logic [15:0] mem     [DEPTH];
  logic [15:0] ref_mem [DEPTH];

  int checks = 0;
  int passes = 0;
  logic [7:0] rd_log[$];
  logic [7:0] wr_log[$];
  int busy_cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error), .checksum(checksum),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out)
  );

  // Synchronous memory: read data appears the cycle after a read-enabled edge.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
    if (mem_read_enable) mem_data_out <= mem[mem_address];
  end

  // Per-cycle protocol monitor and access logger.
  always @(negedge clk) begin
    if (mem_read_enable) rd_log.push_back(mem_address);
    if (mem_write_enable) wr_log.push_back(mem_address);
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (mem_read_enable || mem_write_enable) begin
      checks++;
      if (mem_read_enable && mem_write_enable)
        $display("FAIL enable_exclusive: re=%b we=%b want not both", mem_read_enable, mem_write_enable);
      else passes++;
    end
  end

  task automatic fill_random();
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = 16'($urandom);
    for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = mem[a];
  endtask

  // Reference: ascending word-by-word copy, overwrites included.
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                            output logic [15:0] sum);
    logic [15:0] w;
    sum = '0;
    for (int k = 0; k < n; k++) begin
      w = ref_mem[8'(int'(s) + k)];
      ref_mem[8'(int'(d) + k)] = w;
      sum = 16'(sum + w);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int a = 0; a < int'(DEPTH); a++) if (mem[a] !== ref_mem[a]) n++;
    return n;
  endfunction

  function automatic bit log_ok(input logic [7:0] q[$], input logic [7:0] base, input int n);
    if (q.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) if (q[k] !== 8'(int'(base) + k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_obs();
    rd_log.delete();
    wr_log.delete();
    busy_cyc = 0;
    done_cnt = 0;
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                          output int lat);
    clear_obs();
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, checksum, mem_address, mem_data_in, mem_write_enable, mem_read_enable} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b err=%b cs=%h addr=%h din=%h we=%b re=%b want all 0",
               busy, done, error, checksum, mem_address, mem_data_in, mem_write_enable, mem_read_enable);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] exp;
    fill_random();
    mem[8'h10] = 16'h1234; mem[8'h11] = 16'hABCD; mem[8'h12] = 16'h0001; mem[8'h13] = 16'hFFFF;
    for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = mem[a];
    model_copy(8'h10, 8'h40, 4, exp);
    run_copy(8'h10, 8'h40, 9'd4, lat);
    checks++; if (lat !== 13) $display("FAIL basic_latency: got %0d want 13", lat); else passes++;
    checks++; if (busy_cyc !== 12) $display("FAIL basic_busy: got %0d want 12", busy_cyc); else passes++;
    checks++; if (checksum !== exp) $display("FAIL basic_checksum: got %h want %h", checksum, exp); else passes++;
    checks++; if (error !== 1'b0) $display("FAIL basic_error: got %b want 0", error); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL basic_mem: %0d words differ want 0", mem_diff()); else passes++;
    checks++; if (!log_ok(rd_log, 8'h10, 4) || !log_ok(wr_log, 8'h40, 4))
      $display("FAIL basic_addrs: rd=%p wr=%p want 10.. / 40..", rd_log, wr_log); else passes++;
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] exp;
    fill_random();
    mem[8'hFE] = 16'h000A; mem[8'hFF] = 16'h000B; mem[8'h00] = 16'h000C;
    for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = mem[a];
    model_copy(8'hFE, 8'h7F, 3, exp);
    run_copy(8'hFE, 8'h7F, 9'd3, lat);
    checks++; if (lat !== 10) $display("FAIL wrap_latency: got %0d want 10", lat); else passes++;
    checks++; if (!log_ok(rd_log, 8'hFE, 3)) $display("FAIL wrap_rd_addrs: got %p want fe ff 00", rd_log); else passes++;
    checks++; if (!log_ok(wr_log, 8'h7F, 3)) $display("FAIL wrap_wr_addrs: got %p want 7f 80 81", wr_log); else passes++;
    checks++; if (checksum !== exp) $display("FAIL wrap_checksum: got %h want %h", checksum, exp); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL wrap_mem: %0d words differ want 0", mem_diff()); else passes++;
  endtask

  task automatic test_zero_illegal();
    int lat;
    run_copy(8'h33, 8'h44, 9'd0, lat);
    checks++; if (lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat); else passes++;
    checks++; if (error !== 1'b0 || checksum !== 16'h0) $display("FAIL zero_status: err=%b cs=%h want 0/0000", error, checksum); else passes++;
    checks++; if (rd_log.size() + wr_log.size() + busy_cyc !== 0)
      $display("FAIL zero_no_access: rd=%0d wr=%0d busy=%0d want 0", rd_log.size(), wr_log.size(), busy_cyc); else passes++;
    run_copy(8'h33, 8'h44, 9'd300, lat);
    checks++; if (lat !== 1) $display("FAIL illegal_latency: got %0d want 1", lat); else passes++;
    checks++; if (error !== 1'b1) $display("FAIL illegal_error: got %b want 1", error); else passes++;
    checks++; if (rd_log.size() + wr_log.size() + busy_cyc !== 0)
      $display("FAIL illegal_no_access: rd=%0d wr=%0d busy=%0d want 0", rd_log.size(), wr_log.size(), busy_cyc); else passes++;
  endtask

  task automatic test_overlap();
    int lat; logic [15:0] exp;
    fill_random();
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = mem[a];
    model_copy(8'h00, 8'h01, 3, exp);
    run_copy(8'h00, 8'h01, 9'd3, lat);
    checks++; if (error !== 1'b0) $display("FAIL overlap_error_cleared: got %b want 0", error); else passes++;
    checks++; if (checksum !== exp) $display("FAIL overlap_checksum: got %h want %h", checksum, exp); else passes++;
    checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]})
      $display("FAIL overlap_mem: got %h %h %h %h want %h %h %h %h", mem[0], mem[1], mem[2], mem[3],
               ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]); else passes++;
  endtask

  task automatic test_random();
    int lat; logic [15:0] exp; logic [7:0] s, d; int n;
    for (int it = 0; it < 6; it++) begin
      s = 8'($urandom); d = 8'($urandom); n = int'($urandom_range(1, 24));
      fill_random();
      model_copy(s, d, n, exp);
      run_copy(s, d, 9'(n), lat);
      checks++; if (lat !== 3 * n + 1) $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, 3 * n + 1); else passes++;
      checks++; if (busy_cyc !== 3 * n) $display("FAIL rand%0d_busy: got %0d want %0d", it, busy_cyc, 3 * n); else passes++;
      checks++; if (checksum !== exp) $display("FAIL rand%0d_checksum: got %h want %h", it, checksum, exp); else passes++;
      checks++; if (mem_diff() !== 0) $display("FAIL rand%0d_mem: %0d words differ want 0", it, mem_diff()); else passes++;
      checks++; if (!log_ok(rd_log, s, n) || !log_ok(wr_log, d, n))
        $display("FAIL rand%0d_addrs: rd=%0d wr=%0d entries, want %0d ascending", it, rd_log.size(), wr_log.size(), n); else passes++;
    end
  endtask

  task automatic test_full_memory();
    int lat; logic [15:0] exp;
    fill_random();
    model_copy(8'hC0, 8'hC5, 256, exp);
    run_copy(8'hC0, 8'hC5, 9'd256, lat);
    checks++; if (lat !== 769) $display("FAIL full_latency: got %0d want 769", lat); else passes++;
    checks++; if (checksum !== exp) $display("FAIL full_checksum: got %h want %h", checksum, exp); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL full_mem: %0d words differ want 0", mem_diff()); else passes++;
  endtask

  task automatic test_start_ignored();
    int lat; logic [15:0] exp;
    fill_random();
    model_copy(8'h20, 8'h90, 3, exp);
    clear_obs();
    @(negedge clk);
    src_addr = 8'h20; dst_addr = 8'h90; length = 9'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 2 || k == 5) begin src_addr = 8'h05; dst_addr = 8'h06; length = 9'd7; start = 1'b1; end
      else start = 1'b0;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (lat !== 10) $display("FAIL ignore_latency: got %0d want 10", lat); else passes++;
    checks++; if (busy_cyc !== 9) $display("FAIL ignore_busy: got %0d want 9", busy_cyc); else passes++;
    checks++; if (mem_diff() !== 0 || checksum !== exp)
      $display("FAIL ignore_result: diff=%0d cs=%h want 0 / %h", mem_diff(), checksum, exp); else passes++;
  endtask

  task automatic test_back_to_back();
    int first, second; logic [15:0] exp;
    fill_random();
    model_copy(8'h30, 8'h60, 2, exp);
    model_copy(8'h30, 8'h60, 2, exp);
    clear_obs();
    @(negedge clk);
    src_addr = 8'h30; dst_addr = 8'h60; length = 9'd2; start = 1'b1;
    @(posedge clk);
    first = -1; second = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = k;
        else begin second = k; break; end
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (first !== 7 || second !== 15)
      $display("FAIL b2b_done_times: got %0d,%0d want 7,15", first, second); else passes++;
    checks++; if (busy_cyc !== 12 || mem_diff() !== 0)
      $display("FAIL b2b_result: busy=%0d diff=%0d want 12 / 0", busy_cyc, mem_diff()); else passes++;
  endtask

  task automatic test_mid_reset();
    int lat; logic [15:0] exp;
    fill_random();
    model_copy(8'h50, 8'hA0, 2, exp);
    clear_obs();
    @(negedge clk);
    src_addr = 8'h50; dst_addr = 8'hA0; length = 9'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, error, checksum, mem_address, mem_data_in, mem_write_enable, mem_read_enable} !== '0)
      $display("FAIL midrst_outputs: busy=%b done=%b cs=%h addr=%h din=%h we=%b re=%b want all 0",
               busy, done, checksum, mem_address, mem_data_in, mem_write_enable, mem_read_enable);
    else passes++;
    repeat (30) @(negedge clk);
    checks++; if (wr_log.size() !== 2 || done_cnt !== 0)
      $display("FAIL midrst_abort: writes=%0d dones=%0d want 2 / 0", wr_log.size(), done_cnt); else passes++;
    checks++; if (mem_diff() !== 0) $display("FAIL midrst_mem: %0d words differ want 0", mem_diff()); else passes++;
    model_copy(8'h11, 8'hE0, 1, exp);
    run_copy(8'h11, 8'hE0, 9'd1, lat);
    checks++; if (lat !== 4 || checksum !== exp || mem_diff() !== 0)
      $display("FAIL midrst_recover: lat=%0d cs=%h diff=%0d want 4 / %h / 0", lat, checksum, mem_diff(), exp); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_illegal();
    test_overlap();
    test_random();
    test_full_memory();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
